// File: rtl/tpg_pkg.sv
// Shared constants for the video test-pattern generator.
// Pattern indices, mode encodings and the colour-bar table.
package tpg_pkg;

  localparam logic [2:0] PAT_WHITE  = 3'd0;
  localparam logic [2:0] PAT_GRAY   = 3'd1;
  localparam logic [2:0] PAT_BANDS  = 3'd2;
  localparam logic [2:0] PAT_BARS   = 3'd3;
  localparam logic [2:0] PAT_RAMP   = 3'd4;
  localparam logic [2:0] PAT_CHK    = 3'd5;
  localparam logic [2:0] PAT_SCROLL = 3'd6;
  localparam logic [2:0] PAT_BLACK  = 3'd7;

  localparam logic [3:0] MODE_LAST_PAT = 4'd6;
  localparam logic [3:0] MODE_AUTO     = 4'd15;

  // {R,G,B} on/off per bar; an "on" channel is driven to MAX
  localparam logic [0:7][2:0] BAR_RGB = {
    3'b111, 3'b110, 3'b011, 3'b010,
    3'b101, 3'b100, 3'b001, 3'b000
  };

  function automatic logic [2:0] mode_to_pat(
    input logic [3:0] m
  );
    return (m <= MODE_LAST_PAT) ? m[2:0] : PAT_BLACK;
  endfunction

endpackage

// File: rtl/tpg_frame_ctrl.sv
// Frame-start detect, mode latch, frame counter and optional
// auto-cycle sequencer (compiled in with TPG_AUTO_CYCLE_EN).
module tpg_frame_ctrl
  import tpg_pkg::*;
#(
  parameter int HCNT_W      = 11,
  parameter int VCNT_W      = 12,
  parameter int FCNT_W      = 8,
  parameter int AUTO_FRAMES = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        mode_i,
  input  logic [HCNT_W-1:0] hcnt_i,
  input  logic [VCNT_W-1:0] vcnt_i,
  output logic [2:0]        pat_o,
  output logic [FCNT_W-1:0] fcnt_o
);

  logic              zero, fs, zero_q;
  logic [3:0]        mode_q, mode_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  assign zero = (hcnt_i == '0) && (vcnt_i == '0);
  assign fs   = zero & ~zero_q;

  // _d values double as the bypass for the frame-start pixel
  assign mode_d = fs ? mode_i : mode_q;
  assign fcnt_d = fs ? fcnt_q + 1'b1 : fcnt_q;
  assign fcnt_o = fcnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      mode_q <= '0;
      fcnt_q <= '0;
    end else begin
      zero_q <= zero;
      mode_q <= mode_d;
      fcnt_q <= fcnt_d;
    end
  end

`ifdef TPG_AUTO_CYCLE_EN
  localparam int AW = (AUTO_FRAMES > 1) ?
                      $clog2(AUTO_FRAMES) : 1;

  logic [2:0]    idx_q, idx_d;
  logic [AW-1:0] frm_q, frm_d;

  always_comb begin
    idx_d = idx_q;
    frm_d = frm_q;
    if (fs && mode_i == MODE_AUTO) begin
      if (mode_q != MODE_AUTO) begin
        idx_d = '0;
        frm_d = '0;
      end else if (frm_q == AW'(AUTO_FRAMES - 1)) begin
        frm_d = '0;
        idx_d = (idx_q == PAT_SCROLL) ? '0 : idx_q + 1'b1;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      frm_q <= '0;
    end else begin
      idx_q <= idx_d;
      frm_q <= frm_d;
    end
  end

  assign pat_o = (mode_d == MODE_AUTO) ? idx_d
                                       : mode_to_pat(mode_d);
`else
  assign pat_o = mode_to_pat(mode_d);
`endif

endmodule

// File: rtl/test_pattern_gen.sv
// Two-stage video test-pattern generator datapath.
// Optional auto-cycle mode 15 enabled by TPG_AUTO_CYCLE_EN.
module test_pattern_gen
  import tpg_pkg::*;
#(
  parameter int H_ACTIVE    = 1920,
  parameter int V_ACTIVE    = 1080,
  parameter int HCNT_W      = 11,
  parameter int VCNT_W      = 12,
  parameter int CW          = 8,
  parameter int RAMP_SHIFT  = 3,
  parameter int CHK_SHIFT   = 6,
  parameter int FCNT_W      = 8,
  parameter int AUTO_FRAMES = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        mode,
  input  logic [HCNT_W-1:0] hcnt,
  input  logic [VCNT_W-1:0] vcnt,
  input  logic              de,
  output logic [CW-1:0]     R,
  output logic [CW-1:0]     G,
  output logic [CW-1:0]     B,
  output logic              de_o,
  output logic [2:0]        cur_pat
);

  localparam logic [CW-1:0]     MAX  = '1;
  localparam logic [CW-1:0]     LV_L = MAX >> 4;
  localparam logic [CW-1:0]     LV_M = MAX >> 1;
  localparam logic [HCNT_W-1:0] H_LIM = HCNT_W'(H_ACTIVE);
  localparam logic [VCNT_W-1:0] V_LIM = VCNT_W'(V_ACTIVE);
  localparam logic [VCNT_W-1:0] V_B1 = VCNT_W'(V_ACTIVE / 3);
  localparam logic [VCNT_W-1:0] V_B2 = VCNT_W'(2 * V_ACTIVE / 3);

  logic [2:0]        pat_d;
  logic [FCNT_W-1:0] fcnt;

  tpg_frame_ctrl #(
    .HCNT_W      (HCNT_W),
    .VCNT_W      (VCNT_W),
    .FCNT_W      (FCNT_W),
    .AUTO_FRAMES (AUTO_FRAMES)
  ) u_frame_ctrl (
    .clk    (clk),
    .rst    (rst),
    .mode_i (mode),
    .hcnt_i (hcnt),
    .vcnt_i (vcnt),
    .pat_o  (pat_d),
    .fcnt_o (fcnt)
  );

  logic              blank_d, chk_d, scr_d;
  logic [CW-1:0]     band_d, ramp_d;
  logic [2:0]        bar_d;
  logic [HCNT_W-1:0] rsh, hs;

  assign blank_d = ~de || (hcnt >= H_LIM) || (vcnt >= V_LIM);
  assign band_d  = (vcnt < V_B1) ? LV_L :
                   (vcnt < V_B2) ? LV_M : MAX;
  assign rsh     = hcnt >> RAMP_SHIFT;
  assign ramp_d  = (rsh > HCNT_W'(MAX)) ? MAX : rsh[CW-1:0];
  assign hs      = hcnt + (HCNT_W'(fcnt) << 2);
  assign chk_d   = hcnt[CHK_SHIFT] ^ vcnt[CHK_SHIFT];
  assign scr_d   = hs[CHK_SHIFT] ^ vcnt[CHK_SHIFT];

  // Bar index from a chain of constant boundary compares
  always_comb begin
    bar_d = '0;
    for (int k = 1; k < 8; k++) begin
      if (hcnt >= HCNT_W'(k * (H_ACTIVE / 8)))
        bar_d = 3'(k);
    end
  end

  logic          blank_q, de_q, chk_q, scr_q;
  logic [CW-1:0] band_q, ramp_q;
  logic [2:0]    bar_q, pat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q <= 1'b1;
      de_q    <= 1'b0;
      chk_q   <= 1'b0;
      scr_q   <= 1'b0;
      band_q  <= '0;
      ramp_q  <= '0;
      bar_q   <= '0;
      pat_q   <= '0;
    end else begin
      blank_q <= blank_d;
      de_q    <= de;
      chk_q   <= chk_d;
      scr_q   <= scr_d;
      band_q  <= band_d;
      ramp_q  <= ramp_d;
      bar_q   <= bar_d;
      pat_q   <= pat_d;
    end
  end

  logic [CW-1:0] r_d, g_d, b_d;

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    unique case (pat_q)
      PAT_WHITE:  begin r_d = MAX;  g_d = MAX;  b_d = MAX;  end
      PAT_GRAY:   begin r_d = LV_M; g_d = LV_M; b_d = LV_M; end
      PAT_BANDS:  begin
        r_d = band_q; g_d = band_q; b_d = band_q;
      end
      PAT_BARS:   begin
        r_d = {CW{BAR_RGB[bar_q][2]}};
        g_d = {CW{BAR_RGB[bar_q][1]}};
        b_d = {CW{BAR_RGB[bar_q][0]}};
      end
      PAT_RAMP:   begin
        r_d = ramp_q; g_d = ramp_q; b_d = ramp_q;
      end
      PAT_CHK:    begin
        r_d = {CW{chk_q}}; g_d = {CW{chk_q}}; b_d = {CW{chk_q}};
      end
      PAT_SCROLL: begin
        r_d = {CW{scr_q}}; g_d = {CW{scr_q}}; b_d = {CW{scr_q}};
      end
      PAT_BLACK:  begin r_d = '0; g_d = '0; b_d = '0; end
    endcase
    if (blank_q) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      R       <= '0;
      G       <= '0;
      B       <= '0;
      de_o    <= 1'b0;
      cur_pat <= '0;
    end else begin
      R       <= r_d;
      G       <= g_d;
      B       <= b_d;
      de_o    <= de_q;
      cur_pat <= pat_q;
    end
  end

endmodule
